// File: rtl/neuron_config_controller.sv
// Byte-serial configuration decoder: parses header/address/mode/value frames
// and pulses load when a frame is terminated, so the neuron datapath can latch
// the new configuration.
module neuron_config_controller #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned VALUE_BYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 data,
  input  logic                       load_data,
  output logic                       load,
  output logic [8*VALUE_BYTES-1:0]   value,
  output logic [ADDR_WIDTH-1:0]      address,
  output logic [2:0]                 decay_mode,
  output logic [2:0]                 init_mode_adder,
  output logic [1:0]                 adder_model,
  output logic                       init_mode_acc
);

  localparam int unsigned VALUE_W   = 8 * VALUE_BYTES;
  localparam int unsigned ADDR_HI_W = ADDR_WIDTH - 8;
  localparam logic [6:0]  HDR_TAG   = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_MODE,
    S_VALUE
  } state_t;

  state_t state;

  // Frame parser: one byte per strobed edge; load is a one-cycle registered pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      load            <= 1'b0;
      value           <= '0;
      address         <= '0;
      decay_mode      <= '0;
      init_mode_adder <= '0;
      adder_model     <= '0;
      init_mode_acc   <= 1'b0;
    end else begin
      load <= 1'b0;
      if (load_data) begin
        case (state)
          S_IDLE: begin
            // Only a header byte starts a frame; anything else is noise.
            if (data[7:1] == HDR_TAG) begin
              init_mode_acc <= data[0];
              value         <= '0;
              state         <= S_ADDR_LO;
            end
          end
          S_ADDR_LO: begin
            address[7:0] <= data;
            state        <= S_ADDR_HI;
          end
          S_ADDR_HI: begin
            address[ADDR_WIDTH-1:8] <= data[ADDR_HI_W-1:0];
            state                   <= S_MODE;
          end
          S_MODE: begin
            decay_mode      <= data[7:5];
            init_mode_adder <= data[4:2];
            adder_model     <= data[1:0];
            state           <= S_VALUE;
          end
          S_VALUE: begin
            // 0x00 terminates the frame; any other byte shifts into value.
            if (data == 8'h00) begin
              load  <= 1'b1;
              state <= S_IDLE;
            end else begin
              value <= {value[VALUE_W-9:0], data};
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neuron_config_controller.sv
// Bench for neuron_config_controller: a queue-based frame model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_neuron_config_controller;

  logic        clk;
  logic        rst;
  logic [7:0]  data;
  logic        load_data;
  logic        load;
  logic [31:0] value;
  logic [9:0]  address;
  logic [2:0]  decay_mode;
  logic [2:0]  init_mode_adder;
  logic [1:0]  adder_model;
  logic        init_mode_acc;

  int checks;
  int failures;
  int loads;

  neuron_config_controller dut (
    .clk             (clk),
    .rst             (rst),
    .data            (data),
    .load_data       (load_data),
    .load            (load),
    .value           (value),
    .address         (address),
    .decay_mode      (decay_mode),
    .init_mode_adder (init_mode_adder),
    .adder_model     (adder_model),
    .init_mode_acc   (init_mode_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes of the frame in progress are kept in a queue and
  // the fields are read out of it by position.
  logic [7:0]  fq[$];
  logic        m_load;
  logic [31:0] m_value;
  logic [9:0]  m_addr;
  logic [2:0]  m_decay;
  logic [2:0]  m_imadd;
  logic [1:0]  m_amodel;
  logic        m_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fq.delete();
      m_load = 0; m_value = 0; m_addr = 0; m_decay = 0;
      m_imadd = 0; m_amodel = 0; m_acc = 0;
    end else begin
      m_load = 0;
      if (load_data) begin
        if (fq.size() == 0) begin
          if (data == 8'hFE || data == 8'hFF) begin
            fq.push_back(data);
            m_acc   = data[0];
            m_value = 0;
          end
        end else if (fq.size() >= 4 && data == 8'h00) begin
          m_load = 1;
          fq.delete();
        end else begin
          fq.push_back(data);
          if (fq.size() == 2) m_addr = (m_addr & 10'h300) | 10'(data);
          else if (fq.size() == 3) m_addr = (m_addr & 10'h0FF) | (10'(data & 8'h03) << 8);
          else if (fq.size() == 4) begin
            m_decay  = 3'(data / 32);
            m_imadd  = 3'((data / 4) % 8);
            m_amodel = 2'(data % 4);
          end else begin
            logic [31:0] v;
            v = 0;
            for (int i = 4; i < fq.size(); i++) v = (v * 256) + 32'(fq[i]);
            m_value = v;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, plus load pulse counting
  always @(negedge clk) begin
    if (rst) begin
      chk("load",            32'(load),            32'(m_load));
      chk("value",           value,                m_value);
      chk("address",         32'(address),         32'(m_addr));
      chk("decay_mode",      32'(decay_mode),      32'(m_decay));
      chk("init_mode_adder", 32'(init_mode_adder), 32'(m_imadd));
      chk("adder_model",     32'(adder_model),     32'(m_amodel));
      chk("init_mode_acc",   32'(init_mode_acc),   32'(m_acc));
      if (load) loads++;
    end
  end

  logic [7:0] frm[$];

  // Send frm, with `gap` idle cycles after each byte, then settle
  task automatic send_frame(input int gap);
    foreach (frm[i]) begin
      @(negedge clk);
      data      = frm[i];
      load_data = 1'b1;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        load_data = 1'b0;
        data      = 8'($urandom);
      end
    end
    @(negedge clk);
    load_data = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame2(input string tag, input int l0);
    chk({tag, " loads"},  32'(loads - l0),         32'd1);
    chk({tag, " addr"},   32'(address),            32'h138);
    chk({tag, " acc"},    32'(init_mode_acc),      32'd1);
    chk({tag, " decay"},  32'(decay_mode),         32'd5);
    chk({tag, " imadd"},  32'(init_mode_adder),    32'd3);
    chk({tag, " amodel"}, 32'(adder_model),        32'd3);
    chk({tag, " value"},  value,                   32'h03040506);
  endtask

  task automatic check_frame3(input string tag, input int l0);
    chk({tag, " loads"}, 32'(loads - l0),    32'd1);
    chk({tag, " addr"},  32'(address),       32'h03F);
    chk({tag, " acc"},   32'(init_mode_acc), 32'd0);
    chk({tag, " value"}, value,              32'h00020304);
    chk({tag, " decay"}, 32'(decay_mode),    32'd5);
  endtask

  initial begin
    int l0;
    checks = 0; failures = 0; loads = 0;
    rst = 1'b0; data = 8'h00; load_data = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("init value", value, 32'h0);
    chk("init addr", 32'(address), 32'h0);

    // Test 1: asynchronous reset mid-stream
    frm = '{8'hFF, 8'h38};
    send_frame(0);
    chk("t1 pre addr", 32'(address), 32'h038);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t1 load", 32'(load), 32'd0);
    chk("t1 addr", 32'(address), 32'h0);
    chk("t1 acc",  32'(init_mode_acc), 32'd0);
    chk("t1 value", value, 32'h0);
    chk("t1 modes", 32'({decay_mode, init_mode_adder, adder_model}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Test 2: full frame, extra value bytes shift out
    l0 = loads;
    frm = '{8'hFF, 8'h38, 8'h01, 8'hAF, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00};
    send_frame(0);
    check_frame2("t2", l0);

    // Test 3: header with acc=0, three value bytes
    l0 = loads;
    frm = '{8'hFE, 8'h3F, 8'h00, 8'hAF, 8'h02, 8'h03, 8'h04, 8'h00};
    send_frame(0);
    check_frame3("t3", l0);

    // Test 4: non-header bytes in IDLE are ignored
    l0 = loads;
    frm = '{8'h12, 8'h00, 8'h7E};
    send_frame(0);
    check_frame3("t4", l0 - 1);

    // Test 5: partial frame dropped by reset, then frame 3
    l0 = loads;
    frm = '{8'hFF, 8'h38, 8'h01};
    send_frame(0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    frm = '{8'hFE, 8'h3F, 8'h00, 8'hAF, 8'h02, 8'h03, 8'h04, 8'h00};
    send_frame(0);
    check_frame3("t5", l0);

    // Terminator directly after the mode byte gives value 0
    l0 = loads;
    frm = '{8'hFF, 8'h01, 8'h02, 8'h44, 8'h00};
    send_frame(0);
    chk("empty loads", 32'(loads - l0), 32'd1);
    chk("empty value", value, 32'h0);
    chk("empty addr", 32'(address), 32'h201);

    // Test 6: frame 2 with idle cycles between bytes
    l0 = loads;
    frm = '{8'hFF, 8'h38, 8'h01, 8'hAF, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00};
    send_frame(3);
    check_frame2("t6", l0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
